// File: rtl/dispatch_unit.sv
// dispatch_unit
//   Transmit side of the renamer -> issue-queue interface. Renamed instructions
//   are buffered in a small in-order FIFO. The head entry is offered to the issue
//   queue named by its fu_sel using a zero-cycle valid/ready handshake. A PRN
//   ready scoreboard supplies the source-readiness bits that an issue queue
//   captures when it inserts an entry.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   in_valid / in_ready       renamer handshake (in_ready = FIFO not full)
//   in_*                      instruction payload pushed into the FIFO
//   set_prn_ready / set_prn   FU writeback broadcasts (valid + PRN per lane)
//   iq_queue_ready            per issue queue "has a free slot"
//   iq_inst_valid             one-hot insert strobe toward the issue queues
//   iq_*                      shared payload bus, driven from the FIFO head
//   iq_prn_input_ready        source readiness presented with the insert
//   bad_fu                    one-cycle pulse after a head with fu_sel >= FU_COUNT is dropped
//   stall_count               saturating count of cycles the head was blocked
module dispatch_unit #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [INST_ID_BITS-1:0]                          in_inst_id,
    input  logic [31:0]                                      in_raw_instr,
    input  logic [63:0]                                      in_pc,
    input  logic [$clog2(FU_COUNT):0]                        in_fu_sel,
    input  logic [MAX_OPERANDS-1:0]                          in_prn_input_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            in_prn_input,
    input  logic [MAX_OPERANDS-1:0]                          in_prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            in_prn_output,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]            set_prn_ready,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    input  logic [FU_COUNT-1:0]                              iq_queue_ready,
    output logic [FU_COUNT-1:0]                              iq_inst_valid,
    output logic [INST_ID_BITS-1:0]                          iq_inst_id,
    output logic [31:0]                                      iq_raw_instr,
    output logic [63:0]                                      iq_pc,
    output logic [MAX_OPERANDS-1:0]                          iq_prn_input_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            iq_prn_input,
    output logic [MAX_OPERANDS-1:0]                          iq_prn_output_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            iq_prn_output,
    output logic [MAX_OPERANDS-1:0]                          iq_prn_input_ready,
    output logic                                             bad_fu,
    output logic [31:0]                                      stall_count
);

    localparam int SEL_W = $clog2(FU_COUNT) + 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NPRN  = 1 << PRN_BITS;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]               id;
        logic [31:0]                           raw;
        logic [63:0]                           pc;
        logic [SEL_W-1:0]                      sel;
        logic [MAX_OPERANDS-1:0]               src_v;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src;
        logic [MAX_OPERANDS-1:0]               dst_v;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst;
    } entry_t;

    entry_t              buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [NPRN-1:0]     sb_q, sb_d;
    logic                bad_fu_q;
    logic [31:0]         stall_q;

    entry_t              head;
    entry_t              in_entry;
    logic                head_valid, full, push, pop;
    logic                sel_ok, dispatch, bad_pop, blocked;
    logic [MAX_OPERANDS-1:0] bypass;

    assign in_entry = '{id: in_inst_id, raw: in_raw_instr, pc: in_pc, sel: in_fu_sel,
                        src_v: in_prn_input_valid, src: in_prn_input,
                        dst_v: in_prn_output_valid, dst: in_prn_output};

    assign head       = buf_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    // Full looks only at stored occupancy so in_ready never depends on a same-cycle pop.
    assign full       = (count_q == CNT_W'(BUF_DEPTH));
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign sel_ok     = (head.sel < SEL_W'(FU_COUNT));

    always_comb begin
        iq_inst_valid = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            iq_inst_valid[f] = head_valid && sel_ok && (head.sel == SEL_W'(f)) && iq_queue_ready[f];
        end
    end

    assign dispatch = |iq_inst_valid;
    assign bad_pop  = head_valid && !sel_ok;
    assign pop      = dispatch || bad_pop;
    assign blocked  = head_valid && sel_ok && !dispatch;

    assign iq_inst_id          = head.id;
    assign iq_raw_instr        = head.raw;
    assign iq_pc               = head.pc;
    assign iq_prn_input_valid  = head.src_v;
    assign iq_prn_input        = head.src;
    assign iq_prn_output_valid = head.dst_v;
    assign iq_prn_output       = head.dst;
    assign bad_fu              = bad_fu_q;
    assign stall_count         = stall_q;

    // The receiving IQ slot does not snoop broadcasts on its insert edge, so
    // same-cycle writebacks must be folded into the readiness handed over here.
    // Readiness uses the pre-clear scoreboard, so src == dst still reads ready.
    always_comb begin
        bypass             = '0;
        iq_prn_input_ready = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            for (int k = 0; k < FU_COUNT; k++) begin
                for (int j = 0; j < MAX_OPERANDS; j++) begin
                    if (set_prn_ready[k][j] && (set_prn[k][j] == head.src[i])) begin
                        bypass[i] = 1'b1;
                    end
                end
            end
            iq_prn_input_ready[i] = head.src_v[i] && (sb_q[head.src[i]] || bypass[i]);
        end
    end

    // Broadcast sets are applied first so a dispatch clearing the same PRN wins.
    always_comb begin
        sb_d = sb_q;
        for (int k = 0; k < FU_COUNT; k++) begin
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                if (set_prn_ready[k][j]) begin
                    sb_d[set_prn[k][j]] = 1'b1;
                end
            end
        end
        if (dispatch) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (head.dst_v[i]) begin
                    sb_d[head.dst[i]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            sb_q     <= '1;
            bad_fu_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            sb_q     <= sb_d;
            bad_fu_q <= bad_pop;
            if (blocked && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_unit.sv
module tb_dispatch_unit;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid, in_ready;
    logic [5:0]            in_inst_id;
    logic [31:0]           in_raw_instr;
    logic [63:0]           in_pc;
    logic [2:0]            in_fu_sel;
    logic [2:0]            in_prn_input_valid, in_prn_output_valid;
    logic [2:0][5:0]       in_prn_input, in_prn_output;
    logic [3:0][2:0]       set_prn_ready;
    logic [3:0][2:0][5:0]  set_prn;
    logic [3:0]            iq_queue_ready, iq_inst_valid;
    logic [5:0]            iq_inst_id;
    logic [31:0]           iq_raw_instr;
    logic [63:0]           iq_pc;
    logic [2:0]            iq_prn_input_valid, iq_prn_output_valid, iq_prn_input_ready;
    logic [2:0][5:0]       iq_prn_input, iq_prn_output;
    logic                  bad_fu;
    logic [31:0]           stall_count;

    always #5 clk = ~clk;

    dispatch_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_pc(in_pc),
        .in_fu_sel(in_fu_sel),
        .in_prn_input_valid(in_prn_input_valid), .in_prn_input(in_prn_input),
        .in_prn_output_valid(in_prn_output_valid), .in_prn_output(in_prn_output),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn),
        .iq_queue_ready(iq_queue_ready), .iq_inst_valid(iq_inst_valid),
        .iq_inst_id(iq_inst_id), .iq_raw_instr(iq_raw_instr), .iq_pc(iq_pc),
        .iq_prn_input_valid(iq_prn_input_valid), .iq_prn_input(iq_prn_input),
        .iq_prn_output_valid(iq_prn_output_valid), .iq_prn_output(iq_prn_output),
        .iq_prn_input_ready(iq_prn_input_ready),
        .bad_fu(bad_fu), .stall_count(stall_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0]      id;
        logic [31:0]     raw;
        logic [63:0]     pc;
        logic [2:0]      sel;
        logic [2:0]      sv;
        logic [2:0][5:0] s;
        logic [2:0]      dv;
        logic [2:0][5:0] d;
    } ins_t;

    ins_t        mq[$];
    bit          msb[64];
    bit          mbad;
    logic [31:0] mstall;
    bit          mvalid = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit bcast_hit(input logic [5:0] p);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++)
                if (set_prn_ready[k][j] && set_prn[k][j] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_check();
        logic [3:0] es;
        logic [2:0] er;
        if (!mvalid) return;
        es = '0;
        er = '0;
        if (mq.size() > 0 && mq[0].sel < 4 && iq_queue_ready[mq[0].sel[1:0]])
            es[mq[0].sel[1:0]] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("strobe", 64'(iq_inst_valid), 64'(es));
        chk("bad_fu", 64'(bad_fu), 64'(mbad));
        chk("stall_count", 64'(stall_count), 64'(mstall));
        if (mq.size() > 0) begin
            for (int i = 0; i < 3; i++)
                er[i] = mq[0].sv[i] && (msb[mq[0].s[i]] || bcast_hit(mq[0].s[i]));
            chk("iq_inst_id", 64'(iq_inst_id), 64'(mq[0].id));
            chk("iq_raw_instr", 64'(iq_raw_instr), 64'(mq[0].raw));
            chk("iq_pc", iq_pc, mq[0].pc);
            chk("iq_src", 64'({iq_prn_input_valid, iq_prn_input}), 64'({mq[0].sv, mq[0].s}));
            chk("iq_dst", 64'({iq_prn_output_valid, iq_prn_output}), 64'({mq[0].dv, mq[0].d}));
            chk("iq_src_ready", 64'(iq_prn_input_ready), 64'(er));
        end
    endtask

    task automatic model_update();
        int   pre;
        bit   disp;
        ins_t h;
        ins_t n;
        if (!rst) begin
            mq.delete();
            foreach (msb[p]) msb[p] = 1'b1;
            mbad   = 0;
            mstall = 0;
            mvalid = 1;
            return;
        end
        pre  = mq.size();
        disp = 0;
        mbad = 0;
        if (pre > 0) begin
            h = mq[0];
            if (h.sel >= 4) begin
                void'(mq.pop_front());
                mbad = 1;
            end else if (iq_queue_ready[h.sel[1:0]]) begin
                void'(mq.pop_front());
                disp = 1;
            end else if (mstall != 32'hFFFF_FFFF) begin
                mstall = mstall + 1;
            end
        end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++)
                if (set_prn_ready[k][j]) msb[set_prn[k][j]] = 1'b1;
        if (disp)
            for (int i = 0; i < 3; i++)
                if (h.dv[i]) msb[h.d[i]] = 1'b0;
        if (in_valid && pre < 2) begin
            n.id = in_inst_id;  n.raw = in_raw_instr;  n.pc = in_pc;  n.sel = in_fu_sel;
            n.sv = in_prn_input_valid;  n.s = in_prn_input;
            n.dv = in_prn_output_valid; n.d = in_prn_output;
            mq.push_back(n);
        end
    endtask

    task automatic finish_cycle();
        model_check();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        #4;
        finish_cycle();
    endtask

    task automatic drive(input bit v, input logic [5:0] id, input logic [2:0] sel,
                         input bit sv, input logic [5:0] s0, input bit dv, input logic [5:0] d0,
                         input bit bv, input logic [5:0] bp, input logic [3:0] qr);
        in_valid            = v;
        in_inst_id          = id;
        in_raw_instr        = {8'hA5, 18'h0, id};
        in_pc               = 64'h4000 + 64'(id) * 4;
        in_fu_sel           = sel;
        in_prn_input        = '0;
        in_prn_output       = '0;
        in_prn_input_valid  = {2'b00, sv};
        in_prn_output_valid = {2'b00, dv};
        in_prn_input[0]     = s0;
        in_prn_output[0]    = d0;
        set_prn_ready       = '0;
        set_prn             = '0;
        set_prn_ready[1][0] = bv;
        set_prn[1][0]       = bp;
        iq_queue_ready      = qr;
    endtask

    task automatic drive_random();
        in_valid     = 1'($urandom_range(0, 1));
        in_inst_id   = 6'($urandom);
        in_raw_instr = $urandom;
        in_pc        = {$urandom, $urandom};
        in_fu_sel    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        in_prn_input_valid  = 3'($urandom);
        in_prn_output_valid = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            in_prn_input[i]  = 6'($urandom_range(0, 15));
            in_prn_output[i] = 6'($urandom_range(0, 15));
        end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++) begin
                set_prn_ready[k][j] = ($urandom_range(0, 5) == 0);
                set_prn[k][j]       = 6'($urandom_range(0, 15));
            end
        for (int f = 0; f < 4; f++) iq_queue_ready[f] = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       v;
        logic [5:0] id;
        logic [2:0] sel;
        logic       sv;
        logic [5:0] s0;
        logic       dv;
        logic [5:0] d0;
        logic       bv;
        logic [5:0] bp;
        logic [3:0] qr;
        logic       e_rdy;
        logic [3:0] e_stb;
        logic [5:0] e_id;
        logic       e_pr0;
        logic       e_bad;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl[NV];

    initial begin
        //          v  id sel sv s0 dv d0 bv bp  qr      rdy stb      id pr0 bad
        tbl[0]  = '{1, 5, 2, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0000, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0100, 5, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0000, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 1, 7, 0, 0, 4'hF,   1, 4'b0000, 0, 0, 0};
        tbl[4]  = '{1, 2, 1, 1, 7, 0, 0, 0, 0, 4'hF,   1, 4'b0001, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0010, 2, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 4'hF,   1, 4'b0000, 0, 0, 0};
        tbl[7]  = '{1, 4, 3, 1, 7, 0, 0, 0, 0, 4'hF,   1, 4'b0000, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b1000, 4, 1, 0};
        tbl[9]  = '{1, 10, 0, 0, 0, 1, 9, 0, 0, 4'hF,  1, 4'b0000, 0, 0, 0};
        tbl[10] = '{1, 3, 0, 1, 9, 0, 0, 0, 0, 4'hF,   1, 4'b0001, 10, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 4'hF,   1, 4'b0001, 3, 1, 0};
        tbl[12] = '{1, 11, 1, 0, 0, 1, 4, 0, 0, 4'hF,  1, 4'b0000, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 4, 4'hF,   1, 4'b0010, 11, 0, 0};
        tbl[14] = '{1, 12, 2, 1, 4, 0, 0, 0, 0, 4'hF,  1, 4'b0000, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0100, 12, 0, 0};
        tbl[16] = '{1, 13, 3, 1, 6, 1, 6, 0, 0, 4'hF,  1, 4'b0000, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b1000, 13, 1, 0};
        tbl[18] = '{1, 14, 0, 1, 6, 0, 0, 0, 0, 4'hF,  1, 4'b0000, 0, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0001, 14, 0, 0};
        tbl[20] = '{1, 20, 7, 0, 0, 0, 0, 0, 0, 4'hF,  1, 4'b0000, 0, 0, 0};
        tbl[21] = '{1, 21, 1, 0, 0, 0, 0, 0, 0, 4'hF,  1, 4'b0000, 0, 0, 0};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0010, 21, 0, 1};
        tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF,   1, 4'b0000, 0, 0, 0};

        // reset
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_strobe", 64'(iq_inst_valid), 64'd0);
        chk("rst_bad_fu", 64'(bad_fu), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);

        // table
        for (int r = 0; r < NV; r++) begin
            drive(tbl[r].v, tbl[r].id, tbl[r].sel, tbl[r].sv, tbl[r].s0, tbl[r].dv, tbl[r].d0,
                  tbl[r].bv, tbl[r].bp, tbl[r].qr);
            #4;
            chk($sformatf("tbl%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d_strobe", r), 64'(iq_inst_valid), 64'(tbl[r].e_stb));
            chk($sformatf("tbl%0d_bad_fu", r), 64'(bad_fu), 64'(tbl[r].e_bad));
            if (tbl[r].e_stb != 4'b0000) begin
                chk($sformatf("tbl%0d_id", r), 64'(iq_inst_id), 64'(tbl[r].e_id));
                chk($sformatf("tbl%0d_src_ready0", r), 64'(iq_prn_input_ready[0]), 64'(tbl[r].e_pr0));
            end
            finish_cycle();
        end

        // blocked head: FIFO fills, stall_count counts, release drains in order
        drive(1, 30, 0, 0, 0, 0, 0, 0, 0, 4'b1110); tick();
        drive(1, 31, 0, 0, 0, 0, 0, 0, 0, 4'b1110); tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1, 32, 0, 0, 0, 0, 0, 0, 0, 4'b1110); tick();
        drive(1, 32, 0, 0, 0, 0, 0, 0, 0, 4'b1110); tick();
        chk("stall_after_3", 64'(stall_count), 64'd3);
        drive(1, 32, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        #4;
        chk("release_id30", 64'(iq_inst_id), 64'd30);
        chk("release_rdy_still_0", 64'(in_ready), 64'd0);
        finish_cycle();
        drive(1, 32, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        #4;
        chk("release_id31", 64'(iq_inst_id), 64'd31);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        #4;
        chk("release_id32", 64'(iq_inst_id), 64'd32);
        finish_cycle();
        tick();
        chk("stall_held", 64'(stall_count), 64'd3);

        // reset mid-stall restores an empty FIFO and a fully ready scoreboard
        drive(1, 40, 0, 0, 0, 1, 20, 0, 0, 4'hF); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);   tick();
        drive(1, 41, 0, 0, 0, 0, 0, 0, 0, 4'h0);  tick();
        drive(1, 42, 0, 0, 0, 0, 0, 0, 0, 4'h0);  tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);   tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_stall", 64'(stall_count), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        #4;
        chk("midrst_strobe", 64'(iq_inst_valid), 64'd0);
        finish_cycle();
        drive(1, 43, 1, 1, 20, 0, 0, 0, 0, 4'hF); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
        #4;
        chk("midrst_sb20_ready", 64'(iq_prn_input_ready[0]), 64'd1);
        chk("midrst_strobe43", 64'(iq_inst_valid), 64'b0010);
        finish_cycle();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            drive_random();
            tick();
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
